if_fetch_ctrl: RTL

- Instruction-fetch controller at the consumer end of the program-counter interface.
- Takes the current PC (`address_i`) from `pc_counter` and issues a single-outstanding read to instruction memory.
- Buffers the returned word for decode and drives `PC_next` back into `pc_counter`: hold, advance +4, or redirect.
- `pc_counter` has no enable, so stalls are realised by feeding `address_i` back on `PC_next`.

---
 rtl/if_pkg.sv | 34 +++
 rtl/fetch_buffer.sv | 66 ++++++
 rtl/if_fetch_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and defaults for the instruction-fetch block:
//                fetch FSM state encoding, default PC increment and the
//                fetch-buffer record layout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    // Bytes per fetched instruction; the PC advances by this much.
    localparam int DEFAULT_INSTR_BYTES = 4;

    // Reference widths for the buffer record below.
    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;

    // REQ: free to issue a read. WAIT: one read outstanding.
    typedef enum logic [0:0] {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Contents of the single-entry output buffer presented to decode.
    typedef struct packed {
        logic                  valid;
        logic [PKG_DATA_W-1:0] instr;
        logic [PKG_ADDR_W-1:0] pc;
    } fetch_buf_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
//  Module      : fetch_buffer
//  Description : Single-entry output register between instruction memory and
//                decode. Flush beats load beats consume.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
    import if_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic                     consume_i,
    input  logic                     flush_i,
    input  logic [DATA_WIDTH-1:0]    load_instr_i,
    input  logic [ADDRESS_WIDTH-1:0] load_pc_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o
);

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_q,    pc_d;

    // Next-state: a refill in the same cycle as a consume keeps the entry valid.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = load_instr_i;
            pc_d    = load_pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state register; data only changes on a load so it stays stable under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ============================================================================
//  Module      : if_fetch_ctrl
//  Description : Instruction-fetch controller. Issues single-outstanding reads
//                at the current PC, buffers the returned word for decode and
//                drives PC_next (hold / +INSTR_BYTES / redirect) back into the
//                enable-less pc_counter.
//  Options     : IF_ALIGN_CHECK_EN - block misaligned fetches and raise a
//                sticky fetch_err_o until redirect or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INSTR_BYTES   = DEFAULT_INSTR_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    output logic [ADDRESS_WIDTH-1:0] PC_next,
    output logic                     imem_req_o,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
    output logic                     instr_valid_o,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] instr_pc_o,
    input  logic                     instr_ready_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_addr_i,
    output logic                     fetch_err_o
);

    localparam logic [0:0] ST_REQ  = 1'(REQ);
    localparam logic [0:0] ST_WAIT = 1'(WAIT);

    logic [0:0]               state_q, state_d;
    logic                     drop_pending_q, drop_pending_d;
    logic [ADDRESS_WIDTH-1:0] req_pc_q, req_pc_d;

    logic buf_valid;
    logic buf_free;
    logic misaligned;
    logic issue;
    logic grant;
    logic resp;
    logic load;
    logic consume;

`ifdef IF_ALIGN_CHECK_EN
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(INSTR_BYTES - 1);
    logic fetch_err_q, fetch_err_d;

    assign misaligned = |(address_i & ALIGN_MASK);

    // Sticky error: set while parked on a misaligned PC, cleared only by redirect.
    always_comb begin
        fetch_err_d = fetch_err_q;
        if (redirect_i) begin
            fetch_err_d = 1'b0;
        end else if ((state_q == ST_REQ) && misaligned) begin
            fetch_err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err_o = fetch_err_q;
`else
    assign misaligned  = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    // A request needs room in the buffer (or a same-cycle drain); redirect suppresses it.
    // Gated by rst so nothing is requested while the block is held in reset.
    assign buf_free    = !buf_valid || instr_ready_i;
    assign issue       = !rst && (state_q == ST_REQ) && buf_free && !redirect_i && !misaligned;
    assign grant       = issue && imem_gnt_i;
    assign resp        = (state_q == ST_WAIT) && imem_rvalid_i;
    assign load        = resp && !drop_pending_q && !redirect_i;
    assign consume     = buf_valid && instr_ready_i;

    assign imem_req_o  = issue;
    assign imem_addr_o = address_i;

    // PC feedback: redirect wins, a granted fetch advances, otherwise the PC holds.
    always_comb begin
        if (redirect_i) begin
            PC_next = redirect_addr_i;
        end else if (grant) begin
            PC_next = address_i + ADDRESS_WIDTH'(INSTR_BYTES);
        end else begin
            PC_next = address_i;
        end
    end

    // FSM and bookkeeping next-state; a redirect before the response marks it for discard.
    always_comb begin
        state_d        = state_q;
        drop_pending_d = drop_pending_q;
        req_pc_d       = req_pc_q;
        case (state_q)
            ST_REQ: begin
                if (grant) begin
                    state_d  = ST_WAIT;
                    req_pc_d = address_i;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d        = ST_REQ;
                    drop_pending_d = 1'b0;
                end else if (redirect_i) begin
                    drop_pending_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_REQ;
            drop_pending_q <= 1'b0;
            req_pc_q       <= '0;
        end else begin
            state_q        <= state_d;
            drop_pending_q <= drop_pending_d;
            req_pc_q       <= req_pc_d;
        end
    end

    fetch_buffer #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .consume_i    (consume),
        .flush_i      (redirect_i),
        .load_instr_i (imem_rdata_i),
        .load_pc_i    (req_pc_q),
        .valid_o      (buf_valid),
        .instr_o      (instr_o),
        .pc_o         (instr_pc_o)
    );

    assign instr_valid_o = buf_valid;

endmodule

`default_nettype wire
